// File: rtl/data_mem_unit.sv
// data_mem_unit: byte-addressed RV32 data memory with byte/half/word loads and stores.
// Define DM_MISALIGN_EN to split word-crossing accesses into two beats; otherwise they error.
module data_mem_unit #(
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);
  localparam int WORD_W = ADDR_W - 2;
  localparam int DEPTH  = 2 ** WORD_W;
`ifdef DM_MISALIGN_EN
  localparam bit SPLIT_EN = 1'b1;
`else
  localparam bit SPLIT_EN = 1'b0;
`endif

  // Handshake: a request is taken on a rising edge where req_valid && req_ready; each taken
  // request yields exactly one single-cycle rsp_valid pulse, which the core must always sink.
  typedef enum logic {IDLE = 1'b0, SPLIT = 1'b1} state_t;
  state_t state_q, state_d;

  logic [31:0]       mem [DEPTH];
  logic              ready_q;

  logic              l_we, l_unsigned;
  logic [1:0]        l_size;
  logic [ADDR_W-1:0] l_addr;
  logic [31:0]       l_wdata, lo_word;

  logic              cur_we, cur_unsigned;
  logic [1:0]        cur_size;
  logic [ADDR_W-1:0] cur_addr;
  logic [31:0]       cur_wdata;

  logic [4:0]        sh;
  logic [3:0]        size_mask;
  logic [7:0]        lane_mask;
  logic              crossing, legal;
  logic [WORD_W-1:0] word_a, word_b;
  logic [63:0]       wide_w;
  logic [31:0]       rd_a, rd_b, lo_raw, split_raw;

  logic              accept, do_write, latch_en, rsp_fire, err_d;
  logic [WORD_W-1:0] wr_idx;
  logic [3:0]        wr_mask;
  logic [31:0]       wr_data, rdata_d;
  logic              rsp_valid_q, rsp_err_q;
  logic [31:0]       rsp_rdata_q;

  function automatic logic [31:0] extend(input logic [31:0] raw, input logic [1:0] size,
                                         input logic uns);
    case (size)
      2'b00:   return {{24{~uns & raw[7]}}, raw[7:0]};
      2'b01:   return {{16{~uns & raw[15]}}, raw[15:0]};
      default: return raw;
    endcase
  endfunction

  // The second beat replays the latched request so both beats share one geometry path.
  assign cur_we       = (state_q == SPLIT) ? l_we       : req_we;
  assign cur_size     = (state_q == SPLIT) ? l_size     : req_size;
  assign cur_unsigned = (state_q == SPLIT) ? l_unsigned : req_unsigned;
  assign cur_addr     = (state_q == SPLIT) ? l_addr     : req_addr;
  assign cur_wdata    = (state_q == SPLIT) ? l_wdata    : req_wdata;

  always_comb begin
    size_mask = 4'b0000;
    case (cur_size)
      2'b00:   size_mask = 4'b0001;
      2'b01:   size_mask = 4'b0011;
      2'b10:   size_mask = 4'b1111;
      default: size_mask = 4'b0000;
    endcase
  end

  assign legal     = (cur_size != 2'b11);
  assign sh        = {cur_addr[1:0], 3'b000};
  assign lane_mask = {4'b0000, size_mask} << cur_addr[1:0];
  assign crossing  = |lane_mask[7:4];
  assign word_a    = cur_addr[ADDR_W-1:2];
  assign word_b    = word_a + {{(WORD_W-1){1'b0}}, 1'b1};
  assign wide_w    = {32'h0, cur_wdata} << sh;
  assign rd_a      = mem[word_a];
  assign rd_b      = mem[word_b];
  assign lo_raw    = rd_a >> sh;
  assign split_raw = 32'({rd_b, lo_word} >> sh);

  assign req_ready = ready_q & (state_q == IDLE);
  assign accept    = req_valid & req_ready;

  always_comb begin
    state_d  = state_q;
    do_write = 1'b0;
    wr_idx   = word_a;
    wr_mask  = 4'b0000;
    wr_data  = wide_w[31:0];
    latch_en = 1'b0;
    rsp_fire = 1'b0;
    rdata_d  = 32'h0;
    err_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          rsp_fire = 1'b1;
          if (!legal || (crossing && !SPLIT_EN)) begin
            err_d = 1'b1;
          end else if (crossing) begin
            rsp_fire = 1'b0;
            latch_en = 1'b1;
            state_d  = SPLIT;
            do_write = cur_we;
            wr_mask  = lane_mask[3:0];
          end else begin
            do_write = cur_we;
            wr_mask  = lane_mask[3:0];
            if (!cur_we) rdata_d = extend(lo_raw, cur_size, cur_unsigned);
          end
        end
      end
      SPLIT: begin
        state_d  = IDLE;
        rsp_fire = 1'b1;
        do_write = cur_we;
        wr_idx   = word_b;
        wr_mask  = lane_mask[7:4];
        wr_data  = wide_w[63:32];
        if (!cur_we) rdata_d = extend(split_raw, cur_size, cur_unsigned);
      end
    endcase
  end

  // Writes are gated by rstn so an abandoned second beat never reaches the array.
  always_ff @(posedge clk) begin
    if (rstn && do_write) begin
      for (int k = 0; k < 4; k++) begin
        if (wr_mask[k]) mem[wr_idx][8*k +: 8] <= wr_data[8*k +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (latch_en) begin
      l_we       <= req_we;
      l_size     <= req_size;
      l_unsigned <= req_unsigned;
      l_addr     <= req_addr;
      l_wdata    <= req_wdata;
      lo_word    <= rd_a;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= IDLE;
      ready_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= 32'h0;
    end else begin
      state_q     <= state_d;
      ready_q     <= 1'b1;
      rsp_valid_q <= rsp_fire;
      rsp_err_q   <= err_d;
      rsp_rdata_q <= rdata_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;
endmodule

// File: tb/tb_data_mem_unit.sv
// Bench for data_mem_unit: directed and random load/store traffic checked by a response scoreboard.
// Crossing-access expectations follow DM_MISALIGN_EN.
`timescale 1ns/1ps
module tb_data_mem_unit;
  localparam int ADDR_W = 9;
`ifdef DM_MISALIGN_EN
  localparam int          XLAT   = 2;
  localparam logic        XERR   = 1'b0;
  localparam logic        XREADY = 1'b0;
  localparam logic [31:0] XW0    = 32'hBEEF0000;
  localparam logic [31:0] XW1    = 32'h0000DEAD;
  localparam logic [31:0] XRD    = 32'hDEADBEEF;
  localparam logic [31:0] XWRAP0 = 32'hEF000000;
  localparam logic [31:0] XWRAP1 = 32'h000000BE;
  localparam logic [31:0] XWRAPH = 32'hFFFFBEEF;
`else
  localparam int          XLAT   = 1;
  localparam logic        XERR   = 1'b1;
  localparam logic        XREADY = 1'b1;
  localparam logic [31:0] XW0    = 32'h0;
  localparam logic [31:0] XW1    = 32'h0;
  localparam logic [31:0] XRD    = 32'h0;
  localparam logic [31:0] XWRAP0 = 32'h0;
  localparam logic [31:0] XWRAP1 = 32'h0;
  localparam logic [31:0] XWRAPH = 32'h0;
`endif

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_we = 1'b0;
  logic [1:0]        req_size = 2'b00;
  logic              req_unsigned = 1'b0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [31:0]       req_wdata = 32'h0;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;

  int          vec_cnt = 0;
  int          err_cnt = 0;
  int          cyc = 0;
  logic [32:0] exp_q[$];
  int          due_q[$];
  logic [7:0]  model [512];

  data_mem_unit #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic monitor();
    logic [32:0] e;
    int          d;
    forever begin
      @(negedge clk);
      cyc++;
      if (rsp_valid !== 1'b0) begin
        vec_cnt++;
        if (exp_q.size() == 0) begin
          err_cnt++;
          $display("FAIL unexpected_rsp: rsp_valid=%b at cycle %0d, required no response", rsp_valid, cyc);
        end else begin
          e = exp_q.pop_front();
          d = due_q.pop_front();
          if ({rsp_err, rsp_rdata} !== e) begin
            err_cnt++;
            $display("FAIL rsp_data: err=%b rdata=%h, required err=%b rdata=%h", rsp_err, rsp_rdata, e[32], e[31:0]);
          end
          vec_cnt++;
          if (cyc !== d) begin
            err_cnt++;
            $display("FAIL rsp_timing: response at cycle %0d, required cycle %0d", cyc, d);
          end
        end
      end
    end
  endtask

  task automatic send(input logic we, input logic [1:0] size, input logic uns,
                      input logic [ADDR_W-1:0] addr, input logic [31:0] wdata,
                      input logic [31:0] exp_rdata, input logic exp_err, input int lat, input bit push);
    int w = 0;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    while (req_ready !== 1'b1 && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (req_ready !== 1'b1) begin
      vec_cnt++; err_cnt++;
      $display("FAIL accept_timeout: req_ready=%b after %0d cycles, required 1", req_ready, w);
      req_valid = 1'b0;
    end else begin
      @(posedge clk);
      if (push) begin
        exp_q.push_back({exp_err, exp_rdata});
        due_q.push_back(cyc + lat);
      end
    end
  endtask

  task automatic st(input logic [1:0] size, input logic [ADDR_W-1:0] addr, input logic [31:0] data,
                    input logic err, input int lat);
    send(1'b1, size, 1'b0, addr, data, 32'h0, err, lat, 1'b1);
  endtask

  task automatic ld(input logic [1:0] size, input logic uns, input logic [ADDR_W-1:0] addr,
                    input logic [31:0] exp, input logic err, input int lat);
    send(1'b0, size, uns, addr, 32'h5A5A5A5A, exp, err, lat, 1'b1);
  endtask

  task automatic drain();
    int w = 0;
    @(negedge clk);
    req_valid = 1'b0;
    while (exp_q.size() != 0 && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (exp_q.size() != 0) begin
      vec_cnt++; err_cnt++;
      $display("FAIL missing_rsp: %0d responses outstanding, required 0", exp_q.size());
      exp_q.delete();
      due_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic m_store(input logic [1:0] size, input logic [ADDR_W-1:0] addr, input logic [31:0] data);
    for (int k = 0; k < (1 << size); k++) model[int'(addr) + k] = data[8*k +: 8];
    st(size, addr, data, 1'b0, 1);
  endtask

  task automatic m_load(input logic [1:0] size, input logic uns, input logic [ADDR_W-1:0] addr);
    logic [31:0] v = 32'h0;
    for (int k = 0; k < (1 << size); k++) v[8*k +: 8] = model[int'(addr) + k];
    if (size == 2'b00 && !uns && v[7])  v[31:8]  = '1;
    if (size == 2'b01 && !uns && v[15]) v[31:16] = '1;
    ld(size, uns, addr, v, 1'b0, 1);
  endtask

  task automatic test_reset();
    rstn = 1'b0; req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10;
    req_addr = 9'h100; req_wdata = 32'hCAFEF00D;
    repeat (3) begin
      @(negedge clk);
      vec_cnt++;
      if (req_ready !== 1'b0) begin
        err_cnt++; $display("FAIL reset_ready: req_ready=%b, required 0", req_ready);
      end
      vec_cnt++;
      if ({rsp_valid, rsp_err, rsp_rdata} !== 34'h0) begin
        err_cnt++;
        $display("FAIL reset_rsp: valid=%b err=%b rdata=%h, required all 0", rsp_valid, rsp_err, rsp_rdata);
      end
    end
    rstn = 1'b1; req_valid = 1'b0;
    @(negedge clk);
    vec_cnt++;
    if (req_ready !== 1'b1) begin
      err_cnt++; $display("FAIL release_ready: req_ready=%b, required 1", req_ready);
    end
  endtask

  task automatic test_word();
    st(2'b10, 9'h010, 32'h12345678, 1'b0, 1);
    ld(2'b10, 1'b0, 9'h010, 32'h12345678, 1'b0, 1);
    ld(2'b00, 1'b1, 9'h013, 32'h00000012, 1'b0, 1);
    ld(2'b01, 1'b0, 9'h012, 32'h00001234, 1'b0, 1);
    ld(2'b01, 1'b1, 9'h010, 32'h00005678, 1'b0, 1);
    ld(2'b00, 1'b0, 9'h010, 32'h00000078, 1'b0, 1);
    drain();
  endtask

  task automatic test_byte();
    st(2'b10, 9'h020, 32'h0, 1'b0, 1);
    st(2'b00, 9'h021, 32'h123456A5, 1'b0, 1);
    ld(2'b00, 1'b0, 9'h021, 32'hFFFFFFA5, 1'b0, 1);
    ld(2'b00, 1'b1, 9'h021, 32'h000000A5, 1'b0, 1);
    ld(2'b10, 1'b0, 9'h020, 32'h0000A500, 1'b0, 1);
    st(2'b10, 9'h024, 32'h0, 1'b0, 1);
    st(2'b01, 9'h025, 32'h7777BEEF, 1'b0, 1);
    ld(2'b01, 1'b0, 9'h025, 32'hFFFFBEEF, 1'b0, 1);
    ld(2'b10, 1'b0, 9'h024, 32'h00BEEF00, 1'b0, 1);
    drain();
  endtask

  task automatic test_illegal();
    st(2'b11, 9'h010, 32'hFFFFFFFF, 1'b1, 1);
    ld(2'b10, 1'b0, 9'h010, 32'h12345678, 1'b0, 1);
    ld(2'b11, 1'b0, 9'h010, 32'h0, 1'b1, 1);
    drain();
  endtask

  task automatic test_back_to_back();
    logic [ADDR_W-1:0] a;
    logic [1:0]        sz;
    int                n;
    for (int i = 0; i < 16; i++) m_store(2'b10, 9'h080 + 9'(i * 4), 32'h0);
    for (int i = 0; i < 40; i++) begin
      sz = 2'($urandom_range(0, 2));
      n  = 1 << sz;
      a  = 9'h080 + 9'($urandom_range(0, 15) * 4) + 9'($urandom_range(0, 4 - n));
      if ($urandom_range(0, 1) == 1) m_store(sz, a, $urandom());
      else m_load(sz, 1'($urandom_range(0, 1)), a);
    end
    drain();
  endtask

  task automatic test_cross();
    st(2'b10, 9'h03C, 32'h0, 1'b0, 1);
    st(2'b10, 9'h040, 32'h0, 1'b0, 1);
    drain();
    st(2'b10, 9'h03E, 32'hDEADBEEF, XERR, XLAT);
    @(negedge clk);
    req_valid = 1'b0;
    vec_cnt++;
    if (req_ready !== XREADY) begin
      err_cnt++; $display("FAIL split_ready: req_ready=%b, required %b", req_ready, XREADY);
    end
    drain();
    ld(2'b10, 1'b0, 9'h03C, XW0, 1'b0, 1);
    ld(2'b10, 1'b0, 9'h040, XW1, 1'b0, 1);
    ld(2'b10, 1'b0, 9'h03E, XRD, XERR, XLAT);
    ld(2'b10, 1'b0, 9'h040, XW1, 1'b0, 1);
    drain();
  endtask

  task automatic test_wrap();
    st(2'b10, 9'h1FC, 32'h0, 1'b0, 1);
    st(2'b10, 9'h000, 32'h0, 1'b0, 1);
    st(2'b01, 9'h1FF, 32'h0000BEEF, XERR, XLAT);
    ld(2'b10, 1'b0, 9'h1FC, XWRAP0, 1'b0, 1);
    ld(2'b10, 1'b0, 9'h000, XWRAP1, 1'b0, 1);
    ld(2'b01, 1'b0, 9'h1FF, XWRAPH, XERR, XLAT);
    drain();
  endtask

  task automatic test_reset_nowrite();
    st(2'b10, 9'h100, 32'h0, 1'b0, 1);
    drain();
    rstn = 1'b0; req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10;
    req_addr = 9'h100; req_wdata = 32'hCAFEF00D;
    repeat (3) begin
      @(negedge clk);
      vec_cnt++;
      if ({req_ready, rsp_valid} !== 2'b00) begin
        err_cnt++;
        $display("FAIL reset2_ready: ready=%b valid=%b, required 0 0", req_ready, rsp_valid);
      end
    end
    rstn = 1'b1; req_valid = 1'b0;
    @(negedge clk);
    vec_cnt++;
    if (req_ready !== 1'b1) begin
      err_cnt++; $display("FAIL reset2_release: req_ready=%b, required 1", req_ready);
    end
    ld(2'b10, 1'b0, 9'h100, 32'h0, 1'b0, 1);
    drain();
  endtask

`ifdef DM_MISALIGN_EN
  task automatic test_reset_split();
    st(2'b10, 9'h03C, 32'h0, 1'b0, 1);
    st(2'b10, 9'h040, 32'h0, 1'b0, 1);
    drain();
    send(1'b1, 2'b10, 1'b0, 9'h03E, 32'h11223344, 32'h0, 1'b0, 2, 1'b0);
    @(negedge clk);
    rstn = 1'b0; req_valid = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    vec_cnt++;
    if (rsp_valid !== 1'b0) begin
      err_cnt++; $display("FAIL split_reset_rsp: rsp_valid=%b, required 0", rsp_valid);
    end
    @(negedge clk);
    vec_cnt++;
    if (req_ready !== 1'b1) begin
      err_cnt++; $display("FAIL split_reset_ready: req_ready=%b, required 1", req_ready);
    end
    ld(2'b10, 1'b0, 9'h03C, 32'h33440000, 1'b0, 1);
    ld(2'b10, 1'b0, 9'h040, 32'h00000000, 1'b0, 1);
    drain();
  endtask
`endif

  initial begin
    fork
      monitor();
    join_none
    test_reset();
    test_word();
    test_byte();
    test_illegal();
    test_back_to_back();
    test_cross();
    test_wrap();
    test_reset_nowrite();
`ifdef DM_MISALIGN_EN
    test_reset_split();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule

// File: doc/data_mem_unit.md
# data_mem_unit

Parametrised, byte-addressed data memory for the single-cycle/multicycle RV32 core, sitting between the core's load/store unit and a word-organised storage array. Accepts one load or store per handshake, with byte/half/word size, signed or unsigned load extension, and little-endian byte-lane merging. Accesses crossing a word boundary, including wrap from the top word to word 0, are split into two internal beats by a small state machine that back-pressures the core.

## Interface
Parameters:
- `ADDR_W`, default 9: byte-address width. Depth is 2**(ADDR_W-2) 32-bit words; default 128 words / 512 bytes.

Ports:
- `clk`  in  1: the single clock. All state changes on the rising edge.
- `rstn`  in  1: reset, synchronous, active-low.
- `req_valid`  in  1: request present.
- `req_ready`  out  1: block can accept. A request is accepted on an edge where `req_valid && req_ready`.
- `req_we`  in  1: 1 = store, 0 = load.
- `req_size`  in  2: encoding is 00 byte, 01 half, 10 word, 11 illegal.
- `req_unsigned`  in  1: loads only. 1 = zero-extend, 0 = sign-extend.
- `req_addr`  in  ADDR_W: byte address.
- `req_wdata`  in  32: store data, LSB-aligned.
- `rsp_valid`  out  1: one-cycle pulse per accepted request.
- `rsp_rdata`  out  32: load result, extended. 0 for stores and errors.
- `rsp_err`  out  1: qualified by `rsp_valid`. Illegal size, or a crossing access when the split feature is compiled out.

## Operation
- Access geometry:
  - off = addr[1:0].
  - nbytes = 1/2/4 for size 00/01/10.
  - word = addr[ADDR_W-1:2].
  - An access crosses if off + nbytes > 4.
  - The second word is (word + 1) mod depth; the top word wraps to word 0.
- Byte lane k of a word holds byte address word*4+k (little-endian).
- Stores write only the addressed lanes. All other lanes keep their previous value.
- Loads:
  - Addressed bytes are gathered, lowest address into bit 7:0.
  - The result is then zero- or sign-extended from bit 7 (byte) or bit 15 (half).
  - Word loads ignore `req_unsigned`.
- FSM states:
  - IDLE: `req_ready`=1.
    - Non-crossing accepted request: perform it and stay in IDLE.
    - Crossing request: perform the lanes in the first word, latch the request, go to SPLIT.
  - SPLIT: `req_ready`=0. Perform the lanes in the second word, then return to IDLE.
- Illegal size: no memory write, `rsp_err`=1, `rsp_rdata`=0. Single beat; never enters SPLIT.
- Memory array contents are not reset. The bench initialises every location it reads.
- Reset values: `req_ready`=0 while `rstn`=0, then 1 from the first cycle after reset release. `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0, FSM=IDLE.
- Reset asserted while in SPLIT:
  - The second beat is abandoned and no response is issued.
  - The first-beat write, already committed, persists.

## Timing
- Memory writes occur at the edge where each beat executes.
- Load data is sampled from the array at that same edge.
- Responses are registered:
  - Non-crossing access: `rsp_valid` is high in the cycle after the accepting edge.
  - Crossing access: `rsp_valid` is high two cycles after the accepting edge.
  - `req_ready` is low in the intervening cycle.
- Back-to-back throughput is one request per cycle for non-crossing accesses.
- Read-after-write: a load accepted on the edge after a store's final beat returns the new data. No forwarding is needed because the array updates at the store edge.
- `rsp_valid` lasts exactly one cycle. There is no response back-pressure; the core must sink every response.

## Configuration
- `DM_MISALIGN_EN` defined:
  - Crossing accesses use the SPLIT state as described.
  - `rsp_err` is set only for illegal size.
- `DM_MISALIGN_EN` undefined:
  - No SPLIT state; `req_ready` = `rstn`-released constant 1.
  - Crossing accesses perform no write, return `rsp_rdata`=0, `rsp_err`=1, one cycle after acceptance.
  - Misaligned non-crossing accesses, such as a half at offset 1, still complete normally.

## Test plan
- Reset: `rstn`=0 for 3 cycles with `req_valid`=1 -> no write, `req_ready`=0, `rsp_valid`=0. `req_ready`=1 on the first cycle after release.
- Word store 0x12345678 @0x010, then word load @0x010 -> 0x12345678, one cycle after acceptance. Unsigned byte load @0x013 -> 0x00000012. Signed half load @0x012 -> 0x00001234.
- Zero word 0x020, then byte store 0xA5 @0x021 -> signed byte load @0x021 = 0xFFFFFFA5, unsigned = 0x000000A5, word load @0x020 = 0x0000A500.
- `DM_MISALIGN_EN`, words 0x03C and 0x040 zeroed, word store 0xDEADBEEF @0x03E:
  - `req_ready` low one cycle; `rsp_valid` two cycles after acceptance.
  - Word load @0x03C = 0xBEEF0000; @0x040 = 0x0000DEAD; @0x03E = 0xDEADBEEF, again two cycles after acceptance.
- Wrap: words 0x1FC and 0x000 zeroed, half store 0xBEEF @0x1FF -> word load @0x1FC = 0xEF000000, @0x000 = 0x000000BE. Signed half load @0x1FF = 0xFFFFBEEF.
- Errors:
  - Size 11 store -> `rsp_err`=1, memory unchanged.
  - Without `DM_MISALIGN_EN`: word store @0x03E -> `rsp_err`=1 and both words unchanged.
  - With `DM_MISALIGN_EN`: `rstn` dropped in the SPLIT cycle -> no `rsp_valid`; word 0x03C updated, word 0x040 unchanged.
